// File: rtl/pipe_pkg.sv
// Shared pipeline definitions: register-zero constant, ALU op encodings and
// the packed control bundle carried by the ID/EX, EX/MEM and MEM/WB registers.
package pipe_pkg;

  localparam int unsigned REG_ZERO = 0;
  localparam int unsigned ALU_OP_W = 4;

  typedef enum logic [ALU_OP_W-1:0] {
    ALU_ADD = 4'd0,
    ALU_SUB = 4'd1,
    ALU_AND = 4'd2,
    ALU_OR  = 4'd3,
    ALU_XOR = 4'd4,
    ALU_NOR = 4'd5,
    ALU_SLT = 4'd6,
    ALU_SLL = 4'd7,
    ALU_SRL = 4'd8,
    ALU_SRA = 4'd9,
    ALU_LUI = 4'd10
  } alu_op_e;

  typedef struct packed {
    logic                reg_write;
    logic                mem_read;
    logic                mem_write;
    logic                mem_to_reg;
    logic                alu_src;
    logic [ALU_OP_W-1:0] alu_op;
  } ctrl_t;

endpackage

// File: rtl/load_use_detect.sv
// Combinational load-use hazard detector.
// Ports: ex_* describe the instruction currently in EX, id_* the one in ID;
// luh_o is high when ID needs a value that the load in EX has not yet read.
module load_use_detect #(
  parameter int unsigned REG_AW = 5
) (
  input  logic              ex_valid_i,
  input  logic              ex_mem_read_i,
  input  logic [REG_AW-1:0] ex_write_reg_i,
  input  logic              id_valid_i,
  input  logic [REG_AW-1:0] id_rs_i,
  input  logic [REG_AW-1:0] id_rt_i,
  input  logic              id_uses_rt_i,
  output logic              luh_o
);
  import pipe_pkg::*;

  logic rs_hit;
  logic rt_hit;

  always_comb begin
    rs_hit = (ex_write_reg_i == id_rs_i);
    rt_hit = id_uses_rt_i & (ex_write_reg_i == id_rt_i);
    luh_o  = ex_valid_i & ex_mem_read_i & (ex_write_reg_i != REG_AW'(REG_ZERO)) &
             id_valid_i & (rs_hit | rt_hit);
  end

endmodule

// File: rtl/id_ex_stage.sv
// ID/EX pipeline register with load-use bubble insertion.
// Inputs: id_* decoded instruction, hold_i (freeze), flush_i (kill to bubble).
// Outputs: ex_* registered instruction for EX, stall_o (freeze PC and IF/ID),
// bubble_cnt_o saturating count of load-use bubbles.
module id_ex_stage #(
  parameter int unsigned DATA_W  = 32,
  parameter int unsigned REG_AW  = 5,
  parameter int unsigned ALUOP_W = 4,
  parameter int unsigned CNT_W   = 16
) (
  input  logic               clk_i,
  input  logic               rst_i,
  input  logic               hold_i,
  input  logic               flush_i,
  input  logic               id_valid_i,
  input  logic [DATA_W-1:0]  id_pc_i,
  input  logic [DATA_W-1:0]  id_rs_data_i,
  input  logic [DATA_W-1:0]  id_rt_data_i,
  input  logic [DATA_W-1:0]  id_imm_i,
  input  logic [REG_AW-1:0]  id_rs_i,
  input  logic [REG_AW-1:0]  id_rt_i,
  input  logic [REG_AW-1:0]  id_rd_i,
  input  logic               id_uses_rt_i,
  input  logic               id_reg_write_i,
  input  logic               id_mem_read_i,
  input  logic               id_mem_write_i,
  input  logic               id_mem_to_reg_i,
  input  logic               id_alu_src_i,
  input  logic               id_reg_dst_i,
  input  logic [ALUOP_W-1:0] id_alu_op_i,
  output logic               ex_valid_o,
  output logic [DATA_W-1:0]  ex_pc_o,
  output logic [DATA_W-1:0]  ex_rs_data_o,
  output logic [DATA_W-1:0]  ex_rt_data_o,
  output logic [DATA_W-1:0]  ex_imm_o,
  output logic [REG_AW-1:0]  ex_rs_o,
  output logic [REG_AW-1:0]  ex_rt_o,
  output logic [REG_AW-1:0]  ex_write_reg_o,
  output logic               ex_reg_write_o,
  output logic               ex_mem_read_o,
  output logic               ex_mem_write_o,
  output logic               ex_mem_to_reg_o,
  output logic               ex_alu_src_o,
  output logic [ALUOP_W-1:0] ex_alu_op_o,
  output logic               stall_o,
  output logic [CNT_W-1:0]   bubble_cnt_o
);
  import pipe_pkg::*;

  logic              valid_q,   valid_d;
  logic [DATA_W-1:0] pc_q,      pc_d;
  logic [DATA_W-1:0] rs_data_q, rs_data_d;
  logic [DATA_W-1:0] rt_data_q, rt_data_d;
  logic [DATA_W-1:0] imm_q,     imm_d;
  logic [REG_AW-1:0] rs_q,      rs_d;
  logic [REG_AW-1:0] rt_q,      rt_d;
  logic [REG_AW-1:0] wr_q,      wr_d;
  ctrl_t             ctrl_q,    ctrl_d;
  logic [CNT_W-1:0]  cnt_q,     cnt_d;
  ctrl_t             id_ctrl;
  logic              luh;

  load_use_detect #(.REG_AW(REG_AW)) u_luh (
    .ex_valid_i     (valid_q),
    .ex_mem_read_i  (ctrl_q.mem_read),
    .ex_write_reg_i (wr_q),
    .id_valid_i     (id_valid_i),
    .id_rs_i        (id_rs_i),
    .id_rt_i        (id_rt_i),
    .id_uses_rt_i   (id_uses_rt_i),
    .luh_o          (luh)
  );

  // A flushed ID instruction is discarded, so it must not freeze the front end.
  assign stall_o = luh & ~flush_i;

  always_comb begin
    id_ctrl.reg_write  = id_reg_write_i;
    id_ctrl.mem_read   = id_mem_read_i;
    id_ctrl.mem_write  = id_mem_write_i;
    id_ctrl.mem_to_reg = id_mem_to_reg_i;
    id_ctrl.alu_src    = id_alu_src_i;
    id_ctrl.alu_op     = ALU_OP_W'(id_alu_op_i);
  end

  always_comb begin
    valid_d   = valid_q;
    pc_d      = pc_q;
    rs_data_d = rs_data_q;
    rt_data_d = rt_data_q;
    imm_d     = imm_q;
    rs_d      = rs_q;
    rt_d      = rt_q;
    wr_d      = wr_q;
    ctrl_d    = ctrl_q;
    cnt_d     = cnt_q;
    if (hold_i) begin
      // keep everything
    end else if (flush_i || luh) begin
      valid_d   = 1'b0;
      pc_d      = '0;
      rs_data_d = '0;
      rt_data_d = '0;
      imm_d     = '0;
      rs_d      = '0;
      rt_d      = '0;
      wr_d      = '0;
      ctrl_d    = '0;
      if (!flush_i && cnt_q != '1) cnt_d = cnt_q + CNT_W'(1);
    end else begin
      valid_d   = id_valid_i;
      pc_d      = id_pc_i;
      rs_data_d = id_rs_data_i;
      rt_data_d = id_rt_data_i;
      imm_d     = id_imm_i;
      rs_d      = id_rs_i;
      rt_d      = id_rt_i;
      wr_d      = id_reg_dst_i ? id_rd_i : id_rt_i;
      ctrl_d    = id_valid_i ? id_ctrl : '0;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      valid_q   <= 1'b0;
      pc_q      <= '0;
      rs_data_q <= '0;
      rt_data_q <= '0;
      imm_q     <= '0;
      rs_q      <= '0;
      rt_q      <= '0;
      wr_q      <= '0;
      ctrl_q    <= '0;
      cnt_q     <= '0;
    end else begin
      valid_q   <= valid_d;
      pc_q      <= pc_d;
      rs_data_q <= rs_data_d;
      rt_data_q <= rt_data_d;
      imm_q     <= imm_d;
      rs_q      <= rs_d;
      rt_q      <= rt_d;
      wr_q      <= wr_d;
      ctrl_q    <= ctrl_d;
      cnt_q     <= cnt_d;
    end
  end

  assign ex_valid_o      = valid_q;
  assign ex_pc_o         = pc_q;
  assign ex_rs_data_o    = rs_data_q;
  assign ex_rt_data_o    = rt_data_q;
  assign ex_imm_o        = imm_q;
  assign ex_rs_o         = rs_q;
  assign ex_rt_o         = rt_q;
  assign ex_write_reg_o  = wr_q;
  assign ex_reg_write_o  = ctrl_q.reg_write;
  assign ex_mem_read_o   = ctrl_q.mem_read;
  assign ex_mem_write_o  = ctrl_q.mem_write;
  assign ex_mem_to_reg_o = ctrl_q.mem_to_reg;
  assign ex_alu_src_o    = ctrl_q.alu_src;
  assign ex_alu_op_o     = ALUOP_W'(ctrl_q.alu_op);
  assign bubble_cnt_o    = cnt_q;

endmodule

// File: tb/tb_id_ex_stage.sv
// Scoreboard bench for id_ex_stage: each driven ID cycle pushes the predicted
// EX register state and counter; they are popped and compared after the edge.
module tb_id_ex_stage;
  localparam int unsigned DATA_W  = 32;
  localparam int unsigned REG_AW  = 5;
  localparam int unsigned ALUOP_W = 4;
  localparam int unsigned CNT_W   = 4;

  typedef struct packed {
    logic              valid;
    logic [DATA_W-1:0] pc, rsd, rtd, imm;
    logic [REG_AW-1:0] rs, rt, wr;
    logic              rw, mr, mw, m2r, as;
    logic [ALUOP_W-1:0] aluop;
  } ex_t;

  typedef struct packed {
    logic              valid;
    logic [DATA_W-1:0] pc, rsd, rtd, imm;
    logic [REG_AW-1:0] rs, rt, rd;
    logic              uses_rt, rw, mr, mw, m2r, as, reg_dst;
    logic [ALUOP_W-1:0] aluop;
  } id_t;

  typedef struct packed {
    ex_t              ex;
    logic [CNT_W-1:0] cnt;
  } exp_t;

  logic clk = 1'b0, rst = 1'b1, hold = 1'b0, flush = 1'b0;
  logic id_valid, id_uses_rt, id_rw, id_mr, id_mw, id_m2r, id_as, id_reg_dst;
  logic [DATA_W-1:0] id_pc, id_rsd, id_rtd, id_imm;
  logic [REG_AW-1:0] id_rs, id_rt, id_rd;
  logic [ALUOP_W-1:0] id_aluop;
  logic ex_valid, ex_rw, ex_mr, ex_mw, ex_m2r, ex_as, stall;
  logic [DATA_W-1:0] ex_pc, ex_rsd, ex_rtd, ex_imm;
  logic [REG_AW-1:0] ex_rs, ex_rt, ex_wr;
  logic [ALUOP_W-1:0] ex_aluop;
  logic [CNT_W-1:0] cnt;

  int unsigned n_checks = 0;
  int unsigned n_errors = 0;
  exp_t sb[$];
  ex_t m_ex = '0;
  logic [CNT_W-1:0] m_cnt = '0;

  id_ex_stage #(.DATA_W(DATA_W), .REG_AW(REG_AW), .ALUOP_W(ALUOP_W), .CNT_W(CNT_W)) dut (
    .clk_i(clk), .rst_i(rst), .hold_i(hold), .flush_i(flush),
    .id_valid_i(id_valid), .id_pc_i(id_pc), .id_rs_data_i(id_rsd), .id_rt_data_i(id_rtd),
    .id_imm_i(id_imm), .id_rs_i(id_rs), .id_rt_i(id_rt), .id_rd_i(id_rd),
    .id_uses_rt_i(id_uses_rt), .id_reg_write_i(id_rw), .id_mem_read_i(id_mr),
    .id_mem_write_i(id_mw), .id_mem_to_reg_i(id_m2r), .id_alu_src_i(id_as),
    .id_reg_dst_i(id_reg_dst), .id_alu_op_i(id_aluop),
    .ex_valid_o(ex_valid), .ex_pc_o(ex_pc), .ex_rs_data_o(ex_rsd), .ex_rt_data_o(ex_rtd),
    .ex_imm_o(ex_imm), .ex_rs_o(ex_rs), .ex_rt_o(ex_rt), .ex_write_reg_o(ex_wr),
    .ex_reg_write_o(ex_rw), .ex_mem_read_o(ex_mr), .ex_mem_write_o(ex_mw),
    .ex_mem_to_reg_o(ex_m2r), .ex_alu_src_o(ex_as), .ex_alu_op_o(ex_aluop),
    .stall_o(stall), .bubble_cnt_o(cnt)
  );

  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [191:0] got, input logic [191:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic ex_t dut_ex();
    ex_t e;
    e = '{valid: ex_valid, pc: ex_pc, rsd: ex_rsd, rtd: ex_rtd, imm: ex_imm,
          rs: ex_rs, rt: ex_rt, wr: ex_wr, rw: ex_rw, mr: ex_mr, mw: ex_mw,
          m2r: ex_m2r, as: ex_as, aluop: ex_aluop};
    return e;
  endfunction

  function automatic id_t mk(input logic [REG_AW-1:0] rs, rt, rd, input logic uses_rt,
                             input logic mr, input logic reg_dst, input logic [ALUOP_W-1:0] op);
    id_t i;
    i = '{valid: 1'b1, pc: $urandom, rsd: $urandom, rtd: $urandom, imm: $urandom,
          rs: rs, rt: rt, rd: rd, uses_rt: uses_rt, rw: 1'b1, mr: mr, mw: 1'b0,
          m2r: mr, as: ~reg_dst, reg_dst: reg_dst, aluop: op};
    return i;
  endfunction

  function automatic id_t lw(input logic [REG_AW-1:0] rt);
    return mk(5'd29, rt, 5'd0, 1'b0, 1'b1, 1'b0, 4'd0);
  endfunction

  function automatic id_t add(input logic [REG_AW-1:0] rs, rt, rd);
    return mk(rs, rt, rd, 1'b1, 1'b0, 1'b1, 4'd0);
  endfunction

  task automatic step(input id_t id, input logic h, input logic f);
    exp_t e;
    logic luh;
    {id_valid, id_pc, id_rsd, id_rtd, id_imm, id_rs, id_rt, id_rd, id_uses_rt,
     id_rw, id_mr, id_mw, id_m2r, id_as, id_reg_dst, id_aluop} = id;
    hold = h;
    flush = f;
    #1;
    luh = m_ex.valid && m_ex.mr && (m_ex.wr != 0) && id.valid &&
          ((m_ex.wr == id.rs) || (id.uses_rt && m_ex.wr == id.rt));
    check("stall", stall, luh && !f);
    if (h) begin
    end else if (f || luh) begin
      m_ex = '0;
      if (!f && m_cnt != {CNT_W{1'b1}}) m_cnt = m_cnt + 1'b1;
    end else begin
      m_ex = '{valid: id.valid, pc: id.pc, rsd: id.rsd, rtd: id.rtd, imm: id.imm,
               rs: id.rs, rt: id.rt, wr: id.reg_dst ? id.rd : id.rt,
               rw: id.valid & id.rw, mr: id.valid & id.mr, mw: id.valid & id.mw,
               m2r: id.valid & id.m2r, as: id.valid & id.as,
               aluop: id.valid ? id.aluop : 4'd0};
    end
    e.ex = m_ex;
    e.cnt = m_cnt;
    sb.push_back(e);
    @(posedge clk);
    #1;
    e = sb.pop_front();
    check("ex_state", dut_ex(), e.ex);
    check("bubble_cnt", cnt, e.cnt);
  endtask

  initial begin
    id_t dep, bad;
    {id_valid, id_pc, id_rsd, id_rtd, id_imm, id_rs, id_rt, id_rd, id_uses_rt,
     id_rw, id_mr, id_mw, id_m2r, id_as, id_reg_dst, id_aluop} = '0;
    #3;
    check("reset_ex", dut_ex(), '0);
    check("reset_cnt", cnt, '0);
    check("reset_stall", stall, 1'b0);
    #9 rst = 1'b0;
    @(posedge clk); #1;

    // load then dependent add on rs: one bubble, then replay captured
    step(lw(5'd8), 1'b0, 1'b0);
    dep = add(5'd8, 5'd3, 5'd4);
    step(dep, 1'b0, 1'b0);
    check("bubble_valid", ex_valid, 1'b0);
    step(dep, 1'b0, 1'b0);
    check("replay_rs", ex_rs, 5'd8);

    // addi reading rt slot as destination only: no stall
    step(lw(5'd8), 1'b0, 1'b0);
    step(mk(5'd3, 5'd8, 5'd0, 1'b0, 1'b0, 1'b0, 4'd0), 1'b0, 1'b0);
    check("addi_wr", ex_wr, 5'd8);

    // load to $0 never stalls; flush beats load-use
    step(lw(5'd0), 1'b0, 1'b0);
    step(add(5'd0, 5'd1, 5'd2), 1'b0, 1'b0);
    step(lw(5'd9), 1'b0, 1'b0);
    step(add(5'd1, 5'd9, 5'd2), 1'b0, 1'b1);

    // hold during load-use, then hold+flush together, then release
    step(lw(5'd10), 1'b0, 1'b0);
    dep = add(5'd10, 5'd10, 5'd11);
    for (int i = 0; i < 3; i++) step(dep, 1'b1, 1'b0);
    step(dep, 1'b1, 1'b1);
    step(dep, 1'b0, 1'b0);
    step(dep, 1'b0, 1'b0);

    // invalid ID instruction: control zeroed, data loads
    bad = add(5'd12, 5'd13, 5'd14);
    bad.valid = 1'b0;
    bad.mr = 1'b1;
    step(bad, 1'b0, 1'b0);

    // bring counter to 5, load a valid instruction, then async reset mid-cycle
    for (int i = 0; i < 3; i++) begin
      step(lw(5'd6), 1'b0, 1'b0);
      step(add(5'd6, 5'd1, 5'd2), 1'b0, 1'b0);
    end
    check("cnt_five", cnt, 4'd5);
    step(lw(5'd7), 1'b0, 1'b0);
    {id_valid, id_rs, id_uses_rt} = {1'b1, 5'd7, 1'b0};
    #1;
    check("pre_reset_stall", stall, 1'b1);
    rst = 1'b1;
    #1;
    check("mid_reset_ex", dut_ex(), '0);
    check("mid_reset_cnt", cnt, '0);
    check("mid_reset_stall", stall, 1'b0);
    rst = 1'b0;
    m_ex = '0;
    m_cnt = '0;
    @(posedge clk); #1;

    // saturate the counter, then one more load-use
    for (int i = 0; i < 16; i++) begin
      step(lw(5'd20), 1'b0, 1'b0);
      step(add(5'd1, 5'd20, 5'd2), 1'b0, 1'b0);
    end
    check("cnt_saturated", cnt, 4'hF);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
